// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx -- oversampled UART receiver (start, DATA_WIDTH bits LSB first,
// optional parity, one stop bit).
//
// Every bit lasts Prescale clocks. Each bit is decided by a 2-of-3 majority of
// the samples taken at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1.
// The receiver returns to IDLE at the stop-bit decision point, so a start bit
// that follows a single-period stop bit is still caught.
//
// Optional build macro:
//   RX_SYNC_EN  RX_IN passes through a 2-flop synchronizer (reset value 1)
//               before any logic. All latencies grow by 2 clks.
//               When undefined, RX_IN must already be synchronous to clk.
//
// Ports:
//   clk           system clock, Prescale x bit rate
//   rst           asynchronous active-low reset
//   RX_IN         serial line, idle high
//   PAR_EN        1 = parity bit present (latched at start of frame)
//   PAR_TYP       0 = even, 1 = odd parity (latched at start of frame)
//   Prescale      clocks per bit, even and >= 6 (latched at start of frame)
//   P_DATA        last good byte, held until the next good frame
//   Data_Valid    one-cycle strobe, P_DATA just updated
//   parity_error  one-cycle strobe, parity mismatch, frame dropped
//   stop_error    one-cycle strobe, stop bit sampled 0, frame dropped
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] C_ONE      = 1;
  localparam logic [BCW-1:0]        C_BONE     = 1;
  localparam logic [BCW-1:0]        C_LAST_BIT = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic w_rx;

`ifdef RX_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Reset to 1 so the synchronizer itself never fakes a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;
`else
  assign w_rx = RX_IN;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BCW-1:0]        r_bit_cnt;
  logic                  r_s0;
  logic                  r_s1;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_err;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_parity_error;
  logic                  r_stop_error;

  // Sample points derive from the latched Prescale, so a mid-frame change on
  // the input cannot move them.
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_pt_first;
  logic [PRESCALE_W-1:0] w_pt_dec;
  logic [PRESCALE_W-1:0] w_pt_last;
  logic                  w_at_dec;
  logic                  w_at_end;
  logic                  w_maj;

  assign w_half     = r_prescale >> 1;
  assign w_pt_first = w_half - C_ONE;
  assign w_pt_dec   = w_half + C_ONE;
  assign w_pt_last  = r_prescale - C_ONE;
  assign w_at_dec   = (r_edge_cnt == w_pt_dec);
  assign w_at_end   = (r_edge_cnt == w_pt_last);

  // Third sample is the live line value at the decision count.
  assign w_maj = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

  // ---------------------------------------------------------------------------
  // Receiver FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses <= so all updates in one edge see the
  // values from before that edge; a blocking = would let later statements
  // observe half-updated state and the simulation would no longer match
  // the synthesized flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_edge_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_s0           <= 1'b1;
      r_s1           <= 1'b1;
      r_shift        <= '0;
      r_par_err      <= 1'b0;
      r_par_en       <= 1'b0;
      r_par_typ      <= 1'b0;
      r_prescale     <= '0;
      r_p_data       <= '0;
      r_data_valid   <= 1'b0;
      r_parity_error <= 1'b0;
      r_stop_error   <= 1'b0;
    end else begin
      // Strobes default low, so each one is high for a single clk only.
      r_data_valid   <= 1'b0;
      r_parity_error <= 1'b0;
      r_stop_error   <= 1'b0;

      if (r_state != S_IDLE) begin
        if (r_edge_cnt == w_pt_first) r_s0 <= w_rx;
        if (r_edge_cnt == w_half)     r_s1 <= w_rx;
        r_edge_cnt <= w_at_end ? '0 : r_edge_cnt + C_ONE;
      end

      case (r_state)
        S_IDLE: begin
          r_edge_cnt <= '0;
          r_bit_cnt  <= '0;
          if (!w_rx) begin
            r_state    <= S_START;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_prescale <= Prescale;
            r_par_err  <= 1'b0;
          end
        end

        S_START: begin
          if (w_at_dec && w_maj) begin
            // Start bit did not hold low: treat as a glitch.
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end else if (w_at_end) begin
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_at_dec) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
          if (w_at_end) begin
            if (r_bit_cnt == C_LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + C_BONE;
            end
          end
        end

        S_PARITY: begin
          // Expected parity bit = XOR of data, inverted for odd parity.
          if (w_at_dec) r_par_err <= (w_maj != ((^r_shift) ^ r_par_typ));
          if (w_at_end) r_state <= S_STOP;
        end

        S_STOP: begin
          // Decide at mid-stop and leave immediately so a back-to-back start
          // edge at the end of this stop period is seen from IDLE.
          if (w_at_dec) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            if (!w_maj) begin
              r_stop_error <= 1'b1;
            end else if (r_par_en && r_par_err) begin
              r_parity_error <= 1'b1;
            end else begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_edge_cnt <= '0;
        end
      endcase
    end
  end

  assign P_DATA       = r_p_data;
  assign Data_Valid   = r_data_valid;
  assign parity_error = r_parity_error;
  assign stop_error   = r_stop_error;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
// A table of frames (prescale, parity setup, byte, parity/stop bit, expected
// strobe, expected held P_DATA) is driven in a loop, followed by hand-written
// sequences for glitch, back-to-back, break and mid-frame reset.
// A monitor logs every strobe with its cycle number; expected latency is
// (9 + PAR_EN) * Prescale + Prescale/2 + 2 clks from the first low sample.
// -----------------------------------------------------------------------------
module tb_uart_rx;

`ifdef RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam logic [2:0] K_DV = 3'b001;
  localparam logic [2:0] K_PE = 3'b010;
  localparam logic [2:0] K_SE = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       parity_error;
  logic       stop_error;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t evq[$];

  always @(negedge clk) begin
    if (Data_Valid || parity_error || stop_error)
      evq.push_back('{kind: {stop_error, parity_error, Data_Valid}, data: P_DATA, cyc: cyc});
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [5:0] p, input logic pe);
    return (9 + int'(pe)) * int'(p) + int'(p) / 2 + 2 + SYNC_LAT;
  endfunction

  // Called at a negedge; returns at a negedge right after the stop period.
  // With sc set, the frame-config inputs are disturbed after the start bit.
  task automatic send_frame(input logic [5:0] p, input logic pe, input logic pt,
                            input logic [7:0] d, input logic pb, input logic sb,
                            input logic sc, output int e0);
    logic [10:0] bits;
    int          nb;
    bits     = '1;
    bits[0]  = 1'b0;
    bits[8:1] = d;
    if (pe) begin
      bits[9]  = pb;
      bits[10] = sb;
      nb = 11;
    end else begin
      bits[9] = sb;
      nb = 10;
    end
    Prescale = p;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    e0 = cyc + 1;
    for (int i = 0; i < nb; i++) begin
      RX_IN = bits[i];
      if (sc && i == 1) begin
        Prescale = (p == 6'd16) ? 6'd8 : 6'd16;
        PAR_EN   = ~pe;
        PAR_TYP  = ~pt;
      end
      repeat (int'(p)) @(negedge clk);
    end
    RX_IN    = 1'b1;
    Prescale = p;
    PAR_EN   = pe;
    PAR_TYP  = pt;
  endtask

  // Idle a few cycles, then compare the logged strobe for one frame.
  task automatic check_frame(input string name, input logic [2:0] kind,
                             input logic [7:0] data, input int lat, input int e0);
    repeat (6) @(negedge clk);
    #1;
    check({name, " strobe count"}, 32'(evq.size()), 32'd1);
    if (evq.size() >= 1) begin
      check({name, " strobe kind"}, 32'(evq[0].kind), 32'(kind));
      check({name, " P_DATA at strobe"}, 32'(evq[0].data), 32'(data));
      check({name, " latency"}, 32'(evq[0].cyc - e0), 32'(lat));
    end
    check({name, " P_DATA held"}, 32'(P_DATA), 32'(data));
    evq.delete();
    @(negedge clk);
  endtask

  typedef struct {
    logic [5:0] presc;
    logic       pe;
    logic       pt;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic       scramble;
    logic [2:0] exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int e0;
    int e0b;
    string nm;

    //          presc   pe    pt    data    par   stop  scr   kind  held data
    vecs[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, K_DV, 8'hA5};
    vecs[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, K_DV, 8'h3C};
    vecs[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, K_PE, 8'h3C};
    vecs[3] = '{6'd32, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, K_SE, 8'h3C};
    vecs[4] = '{6'd8,  1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, K_SE, 8'h3C};
    vecs[5] = '{6'd16, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1, K_DV, 8'h81};
    vecs[6] = '{6'd6,  1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, K_DV, 8'h96};
    vecs[7] = '{6'd32, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, K_DV, 8'hC3};
    vecs[8] = '{6'd12, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b1, 1'b0, K_PE, 8'hC3};

    rst      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(negedge clk);
    #1;
    check("reset P_DATA", 32'(P_DATA), 32'h0);
    check("reset Data_Valid", 32'(Data_Valid), 32'h0);
    check("reset parity_error", 32'(parity_error), 32'h0);
    check("reset stop_error", 32'(stop_error), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    evq.delete();

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].presc, vecs[i].pe, vecs[i].pt, vecs[i].data,
                 vecs[i].par_bit, vecs[i].stop_bit, vecs[i].scramble, e0);
      nm = $sformatf("vec%0d", i);
      check_frame(nm, vecs[i].exp_kind, vecs[i].exp_data,
                  exp_latency(vecs[i].presc, vecs[i].pe), e0);
    end

    // Short low pulse: start bit rejected, no strobe.
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (3) @(negedge clk);
    RX_IN = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("glitch no strobe", 32'(evq.size()), 32'd0);
    evq.delete();
    @(negedge clk);
    send_frame(6'd16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, e0);
    check_frame("after glitch", K_DV, 8'h5A, exp_latency(6'd16, 1'b0), e0);

    // Back-to-back frames with a single-period stop bit.
    send_frame(6'd8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0, e0);
    send_frame(6'd8, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0, e0b);
    repeat (6) @(negedge clk);
    #1;
    check("b2b strobe count", 32'(evq.size()), 32'd2);
    if (evq.size() == 2) begin
      check("b2b first kind", 32'(evq[0].kind), 32'(K_DV));
      check("b2b first data", 32'(evq[0].data), 32'h12);
      check("b2b first latency", 32'(evq[0].cyc - e0), 32'(exp_latency(6'd8, 1'b0)));
      check("b2b second kind", 32'(evq[1].kind), 32'(K_DV));
      check("b2b second data", 32'(evq[1].data), 32'h34);
      check("b2b second latency", 32'(evq[1].cyc - e0b), 32'(exp_latency(6'd8, 1'b0)));
    end
    evq.delete();
    @(negedge clk);

    // Break: line low for 80 clks at Prescale 8 -> one stop_error, then the
    // re-entered START sees the line high again and drops out silently.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    e0       = cyc + 1;
    RX_IN    = 1'b0;
    repeat (80) @(negedge clk);
    RX_IN = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    check("break strobe count", 32'(evq.size()), 32'd1);
    if (evq.size() >= 1) begin
      check("break kind", 32'(evq[0].kind), 32'(K_SE));
      check("break latency", 32'(evq[0].cyc - e0), 32'(exp_latency(6'd8, 1'b0)));
    end
    check("break P_DATA held", 32'(P_DATA), 32'h34);
    evq.delete();
    @(negedge clk);

    // Reset in the middle of data bit 4.
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (16) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      RX_IN = b[0];
      repeat (16) @(negedge clk);
    end
    RX_IN = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset P_DATA", 32'(P_DATA), 32'h0);
    check("midreset Data_Valid", 32'(Data_Valid), 32'h0);
    check("midreset parity_error", 32'(parity_error), 32'h0);
    check("midreset stop_error", 32'(stop_error), 32'h0);
    check("midreset no strobe", 32'(evq.size()), 32'd0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    evq.delete();
    send_frame(6'd16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, e0);
    check_frame("after reset", K_DV, 8'hFF, exp_latency(6'd16, 1'b0), e0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
